// File: rtl/gate_test_seq_pkg.sv
// Shared types and constants for the AND-gate self-test sequencer.
package gate_test_pkg;

    localparam int unsigned NUM_VEC = 8;
    localparam int unsigned VEC_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef logic [VEC_W-1:0] vec_t;

    function automatic logic exp_and(input vec_t vec);
        return &vec;
    endfunction

endpackage

// File: rtl/gate_test_seq_if.sv
// Pin bundle between the sequencer (master) and the 3-input gate under test (slave).
interface gate_test_seq_if;

    logic gate_a;
    logic gate_b;
    logic gate_c;
    logic gate_out;

    modport master (
        output gate_a,
        output gate_b,
        output gate_c,
        input  gate_out
    );

    modport slave (
        input  gate_a,
        input  gate_b,
        input  gate_c,
        output gate_out
    );

endinterface

// File: rtl/gate_test_seq_sync_edge_det.sv
// Two-flop synchroniser followed by a single-cycle rising-edge pulse; used for board buttons.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic pulse_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/gate_test_seq.sv
// Self-test sequencer: walks all 8 vectors through the AND gate and tallies mismatches.
// Optional build macro GATE_TEST_SEQ_LOOP_EN: continuous re-runs plus a sticky fail flag.
module gate_test_seq
    import gate_test_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    gate_test_seq_if.master       gate,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [3:0]            err_count,
    output logic [VEC_W-1:0]      first_fail,
    output logic [VEC_W-1:0]      vec_idx
`ifdef GATE_TEST_SEQ_LOOP_EN
    ,
    output logic                  fail_sticky
`endif
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam vec_t             LAST_VEC    = VEC_W'(NUM_VEC - 1);

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    logic start_pulse;

    sync_edge_det u_start_det (
        .clk     (clk),
        .rst_n   (rst_int_n),
        .d_i     (start),
        .pulse_o (start_pulse)
    );

    state_e           state_q, state_d;
    vec_t             vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       err_q, err_d;
    vec_t             ff_q, ff_d;
    logic             mismatch;
`ifdef GATE_TEST_SEQ_LOOP_EN
    logic             sticky_q, sticky_d;
`endif

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q  <= IDLE;
            vec_q    <= '0;
            cnt_q    <= '0;
            err_q    <= '0;
            ff_q     <= '0;
`ifdef GATE_TEST_SEQ_LOOP_EN
            sticky_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            ff_q     <= ff_d;
`ifdef GATE_TEST_SEQ_LOOP_EN
            sticky_q <= sticky_d;
`endif
        end
    end

    assign mismatch = (gate.gate_out != exp_and(vec_q));

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        ff_d     = ff_q;
`ifdef GATE_TEST_SEQ_LOOP_EN
        sticky_d = sticky_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start_pulse) begin
                    state_d = APPLY;
                    vec_d   = '0;
                    err_d   = '0;
                    ff_d    = '0;
                    cnt_d   = SETTLE_LOAD;
                end
            end
            APPLY: begin
                if (cnt_q == '0) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    err_d = err_q + 4'd1;
                    if (err_q == '0) begin
                        ff_d = vec_q;
                    end
`ifdef GATE_TEST_SEQ_LOOP_EN
                    sticky_d = 1'b1;
`endif
                end
                if (vec_q == LAST_VEC) begin
                    state_d = DONE;
                end else begin
                    state_d = APPLY;
                    vec_d   = vec_q + 1'b1;
                    cnt_d   = SETTLE_LOAD;
                end
            end
            DONE: begin
`ifdef GATE_TEST_SEQ_LOOP_EN
                state_d = APPLY;
                vec_d   = '0;
                err_d   = '0;
                ff_d    = '0;
                cnt_d   = SETTLE_LOAD;
`else
                if (start_pulse) begin
                    state_d = APPLY;
                    vec_d   = '0;
                    err_d   = '0;
                    ff_d    = '0;
                    cnt_d   = SETTLE_LOAD;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // The vector stays on the pins through CHECK and DONE; only IDLE parks them low.
    always_comb begin
        {gate.gate_a, gate.gate_b, gate.gate_c} = '0;
        if (state_q != IDLE) begin
            {gate.gate_a, gate.gate_b, gate.gate_c} = vec_q;
        end
    end

    assign busy       = (state_q == APPLY) || (state_q == CHECK);
    assign done       = (state_q == DONE);
    assign pass       = done && (err_q == '0);
    assign err_count  = err_q;
    assign first_fail = ff_q;
    assign vec_idx    = vec_q;
`ifdef GATE_TEST_SEQ_LOOP_EN
    assign fail_sticky = sticky_q;
`endif

endmodule
